// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - two-flop synchronized switch debouncer with edge strobes and press counter
// A level change is accepted only after DEBOUNCE_CYCLES+1 consecutive agreeing synchronized samples.
module switch_debouncer #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       switch_in,
   output logic       switch_out,
   output logic       rise_pulse,
   output logic       fall_pulse,
   output logic [3:0] press_count
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      LOW       = 2'd0,
      WAIT_HIGH = 2'd1,
      HIGH      = 2'd2,
      WAIT_LOW  = 2'd3
   } state_t;

   state_t           state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             sync_meta, sync_in;
   logic             rise_next, fall_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_meta <= 1'b0;
         sync_in   <= 1'b0;
      end else begin
         sync_meta <= switch_in;
         sync_in   <= sync_meta;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= LOW;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         LOW: begin
            if (sync_in) begin
               state_next = WAIT_HIGH;
               cnt_next   = '0;
            end
         end
         WAIT_HIGH: begin
            if (!sync_in) begin
               state_next = LOW;
               cnt_next   = '0;
            end else if (cnt == CNT_MAX) begin
               state_next = HIGH;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         HIGH: begin
            if (!sync_in) begin
               state_next = WAIT_LOW;
               cnt_next   = '0;
            end
         end
         WAIT_LOW: begin
            if (sync_in) begin
               state_next = HIGH;
               cnt_next   = '0;
            end else if (cnt == CNT_MAX) begin
               state_next = LOW;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         default: begin
            state_next = LOW;
            cnt_next   = '0;
         end
      endcase
   end

   assign rise_next = (state == WAIT_HIGH) && (state_next == HIGH);
   assign fall_next = (state == WAIT_LOW) && (state_next == LOW);

   // Outputs are registered from the next state so they line up with the state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         switch_out  <= 1'b0;
         rise_pulse  <= 1'b0;
         fall_pulse  <= 1'b0;
         press_count <= 4'd0;
      end else begin
         switch_out  <= (state_next == HIGH) || (state_next == WAIT_LOW);
         rise_pulse  <= rise_next;
         fall_pulse  <= fall_next;
         press_count <= press_count + {3'b000, rise_next};
      end
   end

endmodule

// File: tb/tb_switch_debouncer.sv
// tb/tb_switch_debouncer.sv - self-checking bench for switch_debouncer with a run-length reference model
module tb_switch_debouncer;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       switch_in;
   logic       switch_out;
   logic       rise_pulse;
   logic       fall_pulse;
   logic [3:0] press_count;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference: accepted level flips once the synchronized input disagrees for D+1 samples in a row.
   logic m_s1, m_s2, m_lvl, m_rise, m_fall;
   int   m_run;
   int   m_cnt;

   switch_debouncer #(.DEBOUNCE_CYCLES(D)) dut (
      .clk         (clk),
      .reset       (reset),
      .switch_in   (switch_in),
      .switch_out  (switch_out),
      .rise_pulse  (rise_pulse),
      .fall_pulse  (fall_pulse),
      .press_count (press_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_s1 = 1'b0; m_s2 = 1'b0; m_lvl = 1'b0;
         m_rise = 1'b0; m_fall = 1'b0; m_run = 0; m_cnt = 0;
      end else begin
         m_rise = 1'b0;
         m_fall = 1'b0;
         if (m_s2 != m_lvl) begin
            m_run++;
            if (m_run == D + 1) begin
               m_lvl = ~m_lvl;
               m_run = 0;
               if (m_lvl) begin
                  m_rise = 1'b1;
                  m_cnt  = (m_cnt + 1) % 16;
               end else begin
                  m_fall = 1'b1;
               end
            end
         end else begin
            m_run = 0;
         end
         m_s2 = m_s1;
         m_s1 = switch_in;
      end
   end

   always @(negedge clk) begin
      check("model_switch_out", int'(switch_out), int'(m_lvl));
      check("model_rise_pulse", int'(rise_pulse), int'(m_rise));
      check("model_fall_pulse", int'(fall_pulse), int'(m_fall));
      check("model_press_count", int'(press_count), m_cnt);
      if (rise_pulse && fall_pulse) check("pulse_exclusive", 1, 0);
   end

   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic expect_rise(input string name, input int cnt_exp);
      edges(6);
      check({name, "_out_before"}, int'(switch_out), 0);
      check({name, "_rise_before"}, int'(rise_pulse), 0);
      edges(1);
      check({name, "_out"}, int'(switch_out), 1);
      check({name, "_rise"}, int'(rise_pulse), 1);
      check({name, "_count"}, int'(press_count), cnt_exp);
      edges(1);
      check({name, "_rise_after"}, int'(rise_pulse), 0);
   endtask

   initial begin
      reset     = 1'b1;
      switch_in = 1'b0;
      #30;
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         edges(1);
         check("idle_out", int'(switch_out), 0);
         check("idle_count", int'(press_count), 0);
      end

      // clean rise
      switch_in = 1'b1;
      expect_rise("clean_rise", 1);
      edges(4);

      // clean fall
      switch_in = 1'b0;
      edges(6);
      check("clean_fall_out_before", int'(switch_out), 1);
      edges(1);
      check("clean_fall_out", int'(switch_out), 0);
      check("clean_fall_pulse", int'(fall_pulse), 1);
      check("clean_fall_count", int'(press_count), 1);
      edges(1);
      check("clean_fall_pulse_after", int'(fall_pulse), 0);
      edges(4);

      // bounce 1,0,1,0 every 2 cycles, then settle high
      for (int i = 0; i < 4; i++) begin
         switch_in = (i % 2 == 0);
         edges(2);
         check("bounce_out", int'(switch_out), 0);
      end
      switch_in = 1'b1;
      expect_rise("bounce_rise", 2);
      switch_in = 1'b0;
      edges(12);

      // 17 press/release cycles from a fresh reset
      reset = 1'b1;
      edges(1);
      reset = 1'b0;
      for (int k = 1; k <= 17; k++) begin
         switch_in = 1'b1;
         edges(10);
         check("press_seq", int'(press_count), k % 16);
         switch_in = 1'b0;
         edges(10);
      end

      // reset while HIGH aborts without a fall strobe, then requalifies
      switch_in = 1'b1;
      edges(10);
      check("high_before_reset", int'(switch_out), 1);
      reset = 1'b1;
      #1;
      check("async_reset_out", int'(switch_out), 0);
      check("async_reset_count", int'(press_count), 0);
      check("async_reset_fall", int'(fall_pulse), 0);
      edges(2);
      check("reset_hold_fall", int'(fall_pulse), 0);
      reset = 1'b0;
      expect_rise("rise_after_high_reset", 1);
      switch_in = 1'b0;
      edges(12);

      // reset while WAIT_HIGH with cnt=2
      switch_in = 1'b1;
      edges(5);
      reset = 1'b1;
      #1;
      check("wait_reset_out", int'(switch_out), 0);
      check("wait_reset_rise", int'(rise_pulse), 0);
      edges(1);
      reset = 1'b0;
      expect_rise("rise_after_wait_reset", 1);
      edges(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
